// File: rtl/lut_access_sched_pkg.sv
// Shared constants and state encoding for the LUT access scheduler.
package lut_access_sched_pkg;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_LOG2_DEPTH   = 3;
    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_LOG2_NUM_REQ = 2;
    localparam int LOOKUP_LAT       = 2;

endpackage

// File: rtl/lut_access_sched_if.sv
// Client-side bus of the LUT scheduler: lookup requests/responses plus config write port.
interface lut_access_sched_if
    import lut_access_sched_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOG2_DEPTH = DEF_LOG2_DEPTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*LOG2_DEPTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [WIDTH-1:0]              rsp_data;
    logic                          cfg_we;
    logic [LOG2_DEPTH-1:0]         cfg_addr;
    logic [WIDTH-1:0]              cfg_data;
    logic                          cfg_ack;
    logic                          ready;

    modport master (
        output req, req_addr, cfg_we, cfg_addr, cfg_data,
        input  gnt, rsp_valid, rsp_data, cfg_ack, ready
    );

    modport slave (
        input  req, req_addr, cfg_we, cfg_addr, cfg_data,
        output gnt, rsp_valid, rsp_data, cfg_ack, ready
    );
endinterface

// File: rtl/lut_access_sched_rr_arbiter.sv
// Combinational round-robin arbiter; searches upward from ptr+1 with wrap-around.
module lut_access_sched_rr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOG2_NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]      req,
    input  logic [LOG2_NUM_REQ-1:0] ptr,
    input  logic                    en,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [LOG2_NUM_REQ-1:0] idx
);
    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (en && !found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = LOG2_NUM_REQ'(j);
            end
        end
    end
endmodule

// File: rtl/lut_access_sched.sv
// Single-port LUT owner: init fill, config-write priority, round-robin lookups
// through an address-register / data-register read pipeline.
module lut_access_sched
    import lut_access_sched_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int LOG2_DEPTH   = DEF_LOG2_DEPTH,
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int LOG2_NUM_REQ = DEF_LOG2_NUM_REQ
) (
    input  logic               clock,
    input  logic               reset_n,
    lut_access_sched_if.slave  bus
);
    localparam int DEPTH = 2**LOG2_DEPTH;

    state_t                  state;
    logic [LOG2_DEPTH-1:0]   cnt;
    logic [LOG2_DEPTH:0]     cnt_p1;
    logic [LOG2_NUM_REQ-1:0] ptr;
    logic                    ready;
    logic                    run, cfg_go, lk_go;
    logic [NUM_REQ-1:0]      gnt;
    logic [LOG2_NUM_REQ-1:0] gnt_idx;
    logic [LOG2_DEPTH-1:0]   sel_addr;

    logic                    we;
    logic [LOG2_DEPTH-1:0]   waddr;
    logic [WIDTH-1:0]        wdata;
    logic [WIDTH-1:0]        lut [DEPTH];

    logic [LOOKUP_LAT:1]     vld_pipe;
    logic [LOG2_NUM_REQ-1:0] idx1;
    logic [LOG2_DEPTH-1:0]   addr1;
    logic [NUM_REQ-1:0]      oh2;
    logic [WIDTH-1:0]        rsp_data;

    assign run      = (state == ST_RUN);
    assign cfg_go   = run & bus.cfg_we;
    assign lk_go    = |gnt;
    assign sel_addr = bus.req_addr[int'(gnt_idx)*LOG2_DEPTH +: LOG2_DEPTH];

    lut_access_sched_rr_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .LOG2_NUM_REQ (LOG2_NUM_REQ)
    ) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .en  (run & ~bus.cfg_we),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
            cnt   <= '0;
            ptr   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LOG2_DEPTH'(DEPTH-1)) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: if (lk_go) ptr <= gnt_idx;
                default: state <= ST_INIT;
            endcase
        end
    end

    // Single write port shared by the init fill and config writes (never both).
    assign cnt_p1 = {1'b0, cnt} + 1'b1;
    assign we     = (state == ST_INIT) | cfg_go;
    assign waddr  = run ? bus.cfg_addr : cnt;
    assign wdata  = run ? bus.cfg_data : WIDTH'(cnt_p1);

    always_ff @(posedge clock) begin
        if (we) lut[waddr] <= wdata;
    end

    // Read happens on the same edge as a possible write, so it sees the old value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            idx1     <= '0;
            addr1    <= '0;
            oh2      <= '0;
            rsp_data <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LOOKUP_LAT-1:1], lk_go};
            if (lk_go) begin
                idx1  <= gnt_idx;
                addr1 <= sel_addr;
            end
            if (vld_pipe[1]) begin
                oh2      <= NUM_REQ'(1) << idx1;
                rsp_data <= lut[addr1];
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.cfg_ack   = cfg_go;
    assign bus.ready     = ready;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_valid = vld_pipe[LOOKUP_LAT] ? oh2 : '0;
endmodule

// File: tb/tb_lut_access_sched.sv
// Directed bench for lut_access_sched: init fill, round-robin, config priority,
// read/write ordering, data-width wrap and mid-operation reset.
module tb_lut_access_sched;
    logic clock;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;
    int   n;

    lut_access_sched_if #(.WIDTH(8), .LOG2_DEPTH(3), .NUM_REQ(4)) bus ();
    lut_access_sched_if #(.WIDTH(3), .LOG2_DEPTH(3), .NUM_REQ(4)) bus3 ();

    lut_access_sched #(.WIDTH(8), .LOG2_DEPTH(3), .NUM_REQ(4), .LOG2_NUM_REQ(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    lut_access_sched #(.WIDTH(3), .LOG2_DEPTH(3), .NUM_REQ(4), .LOG2_NUM_REQ(2)) dut3 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] rr_gnt  [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [7:0] rr_data [5] = '{8'd6, 8'd7, 8'd8, 8'd5, 8'd6};

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        bus.req       = 4'b1111;
        bus.req_addr  = '0;
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus3.req      = '0;
        bus3.req_addr = '0;
        bus3.cfg_we   = 1'b0;
        bus3.cfg_addr = '0;
        bus3.cfg_data = '0;
        repeat (2) cyc();

        chk("rst_ready",     32'(bus.ready),     32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        chk("rst_gnt",       32'(bus.gnt),       32'd0);
        chk("rst_cfg_ack",   32'(bus.cfg_ack),   32'd0);
        bus.cfg_we = 1'b0;

        // Init: requests held throughout must not be granted.
        reset_n = 1'b1;
        n = 0;
        while (!bus.ready && n < 20) begin
            cyc();
            n++;
            if (!bus.ready) chk("init_gnt", 32'(bus.gnt), 32'd0);
        end
        chk("init_cycles", 32'(n), 32'd8);

        // Back-to-back lookups of addr 0..7 by req[0]; dut3 reads its wrapped entries.
        for (int k = 0; k < 10; k++) begin
            if (k >= 2) begin
                chk("fill_valid", 32'(bus.rsp_valid), 32'b0001);
                chk("fill_data",  32'(bus.rsp_data),  32'(k - 1));
            end else begin
                chk("fill_idle", 32'(bus.rsp_valid), 32'd0);
            end
            if (k == 2) begin
                chk("wrap_valid", 32'(bus3.rsp_valid), 32'b0001);
                chk("wrap_lut7",  32'(bus3.rsp_data),  32'd0);
            end
            if (k == 3) chk("wrap_lut0", 32'(bus3.rsp_data), 32'd1);
            bus3.req           = (k < 2) ? 4'b0001 : 4'b0000;
            bus3.req_addr[2:0] = (k == 0) ? 3'd7 : 3'd0;
            if (k < 8) begin
                bus.req           = 4'b0001;
                bus.req_addr[2:0] = 3'(k);
                #1;
                chk("fill_gnt", 32'(bus.gnt), 32'b0001);
            end else begin
                bus.req = 4'b0000;
            end
            cyc();
        end
        chk("hold_valid", 32'(bus.rsp_valid), 32'd0);
        chk("hold_data",  32'(bus.rsp_data),  32'd8);

        // Round-robin with all requesters active, starting from ptr=0.
        bus.req      = 4'b1111;
        bus.req_addr = {3'd7, 3'd6, 3'd5, 3'd4};
        for (int k = 0; k < 7; k++) begin
            if (k >= 2) begin
                chk("rr_valid", 32'(bus.rsp_valid), 32'(rr_gnt[k-2]));
                chk("rr_data",  32'(bus.rsp_data),  32'(rr_data[k-2]));
            end
            if (k < 5) begin
                #1;
                chk("rr_gnt", 32'(bus.gnt), 32'(rr_gnt[k]));
            end else begin
                bus.req = 4'b0000;
            end
            cyc();
        end

        // Config write beats pending lookups.
        chk("cfg_idle_valid", 32'(bus.rsp_valid), 32'd0);
        bus.req      = 4'b1111;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd3;
        bus.cfg_data = 8'hA5;
        #1;
        chk("cfg_ack", 32'(bus.cfg_ack), 32'd1);
        chk("cfg_gnt", 32'(bus.gnt),     32'd0);
        cyc();
        bus.cfg_we         = 1'b0;
        bus.req            = 4'b0100;
        bus.req_addr[8:6]  = 3'd3;
        #1;
        chk("cfg_ack_off", 32'(bus.cfg_ack), 32'd0);
        chk("cfg_rd_gnt",  32'(bus.gnt),     32'b0100);
        cyc();
        bus.req = 4'b0000;
        cyc();
        chk("cfg_rd_valid", 32'(bus.rsp_valid), 32'b0100);
        chk("cfg_rd_data",  32'(bus.rsp_data),  32'hA5);

        // Write in T+1 is not seen by the lookup granted in T.
        bus.req           = 4'b0010;
        bus.req_addr[5:3] = 3'd5;
        #1;
        chk("ord_gnt", 32'(bus.gnt), 32'b0010);
        cyc();
        bus.req      = 4'b0000;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd5;
        bus.cfg_data = 8'h3C;
        #1;
        chk("ord_cfg_ack", 32'(bus.cfg_ack), 32'd1);
        cyc();
        chk("ord_old_valid", 32'(bus.rsp_valid), 32'b0010);
        chk("ord_old_data",  32'(bus.rsp_data),  32'd6);
        bus.cfg_we = 1'b0;
        bus.req    = 4'b0010;
        #1;
        chk("ord_gnt2", 32'(bus.gnt), 32'b0010);
        cyc();
        bus.req = 4'b0000;
        cyc();
        chk("ord_new_valid", 32'(bus.rsp_valid), 32'b0010);
        chk("ord_new_data",  32'(bus.rsp_data),  32'h3C);

        // Reset with two lookups in flight.
        bus.req           = 4'b0001;
        bus.req_addr[2:0] = 3'd3;
        #1;
        chk("mid_gnt0", 32'(bus.gnt), 32'b0001);
        cyc();
        bus.req           = 4'b0100;
        bus.req_addr[8:6] = 3'd0;
        #1;
        chk("mid_gnt2", 32'(bus.gnt), 32'b0100);
        #1;
        reset_n = 1'b0;
        bus.req = 4'b0000;
        #1;
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.ready),     32'd0);
        chk("mid_rst_data",  32'(bus.rsp_data),  32'd0);
        repeat (2) begin
            cyc();
            chk("mid_rst_drop", 32'(bus.rsp_valid), 32'd0);
        end
        reset_n = 1'b1;
        n = 0;
        while (!bus.ready && n < 20) begin
            cyc();
            n++;
            if (!bus.ready) chk("reinit_valid", 32'(bus.rsp_valid), 32'd0);
        end
        chk("reinit_cycles", 32'(n), 32'd8);
        bus.req           = 4'b0001;
        bus.req_addr[2:0] = 3'd3;
        #1;
        chk("reinit_gnt", 32'(bus.gnt), 32'b0001);
        cyc();
        bus.req = 4'b0000;
        cyc();
        chk("reinit_valid3", 32'(bus.rsp_valid), 32'b0001);
        chk("reinit_lut3",   32'(bus.rsp_data),  32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lut_access_sched.md
Name: lut_access_sched

Overview:
Controller that owns a single-port lookup table (LUT) and shares it between NUM_REQ lookup requesters plus one configuration writer.
- After reset it sequences an init pass that fills entry j with j+1.
- It then arbitrates lookups round-robin, one per cycle, through a 2-stage registered read pipeline: address register, then data register.
- It sits between the datapath clients and the LUT storage, replacing per-client LUT copies.

Parameters:
- WIDTH, 8, LUT entry data width.
- LOG2_DEPTH, 3, address width; DEPTH = 2**LOG2_DEPTH entries.
- NUM_REQ, 4, number of lookup requesters (≥2).
- LOG2_NUM_REQ, 2, width of requester index; must satisfy 2**LOG2_NUM_REQ ≥ NUM_REQ.

Ports:
- clock  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  lookup request per requester, level, held until granted.
- req_addr  input  NUM_REQ*LOG2_DEPTH  flattened addresses; requester i uses bits [i*LOG2_DEPTH +: LOG2_DEPTH].
- gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as accepted req.
- rsp_valid  output  NUM_REQ  one-hot, 1-cycle pulse, registered.
- rsp_data  output  WIDTH  lookup result, valid when any rsp_valid bit is high, registered.
- cfg_we  input  1  config write request, level, held until cfg_ack.
- cfg_addr  input  LOG2_DEPTH  config write address.
- cfg_data  input  WIDTH  config write data.
- cfg_ack  output  1  combinational; cfg_we & (state==RUN).
- ready  output  1  registered; high once init completes.

Behaviour:
- Reset (async, reset_n=0):
  - state=INIT, init counter=0, round-robin pointer=0.
  - ready=0, rsp_valid=0, rsp_data=0; pipeline registers cleared.
  - gnt=0 and cfg_ack=0 while in reset.
  - LUT contents are not reset; they are rewritten by INIT.
- INIT:
  - Each cycle: lut[cnt] <= (cnt+1) truncated to WIDTH bits (mod 2**WIDTH); cnt increments.
  - After the cycle writing cnt=DEPTH-1: state -> RUN and ready <= 1. Init takes exactly DEPTH cycles after reset release.
  - gnt=0 and cfg_ack=0 throughout INIT; pending req/cfg_we are simply held by the clients.
- RUN priority: cfg_we beats lookups.
  - If cfg_we: cfg_ack=1, gnt=0; lut[cfg_addr] <= cfg_data at the end of the cycle.
  - Otherwise, if any req: grant the first requesting index, searching from (ptr+1) mod NUM_REQ upward with wrap-around. gnt[i]=1; ptr <= i.
- Lookup latency:
  - Grant in cycle T: address and index are captured at the end of T.
  - The LUT is read at the end of T+1.
  - rsp_valid[i]=1 and rsp_data valid during T+2. Fixed latency 2, throughput 1 per cycle, back-to-back grants pipeline.
- Read/write ordering:
  - A cfg write in any cycle ≤ T is visible to a lookup granted in T.
  - A write in T+1 is not visible to it (read-before-write on the same edge).
- No lookup in flight: rsp_valid=0; rsp_data holds its last value.
- ready stays 1 until the next reset.
- Reset mid-operation: in-flight lookups are dropped (no rsp_valid), a pending cfg write is lost unless acked before reset, and INIT reruns.
- Starvation bound: with cfg_we low, every requesting client is granted within NUM_REQ cycles.

Decomposition:
- Shared package/include: state encodings ST_INIT / ST_RUN, default WIDTH / LOG2_DEPTH / NUM_REQ constants, lookup latency constant (2).
- One natural sub-module: rr_arbiter.
  - Inputs: req, ptr, enable. Output: one-hot gnt plus encoded index.
  - Purely combinational, with its ptr register in the parent.
- LUT storage is an inferred reg array in lut_access_sched.

Test Plan:
- Init fill: release reset and wait for ready (expect exactly 8 cycles); then req[0] with addresses 0..7 -> rsp_data 1..8, each 2 cycles after its grant.
- Round-robin: all 4 req held high -> gnt order 0? no: 1,2,3,0,1 starting from ptr=0. rsp_valid pulses follow 2 cycles later in the same order, each with the correct data.
- Config priority: cfg_we with addr=3, data=0xA5 while req=4'b1111 -> cfg_ack=1 and gnt=0 that cycle. The next lookup of addr 3 returns 0xA5.
- Read/write ordering: grant req[1] for addr 5 in T, then cfg write addr 5 = 0x3C in T+1 -> rsp_data=6 in T+2. A lookup of addr 5 granted in T+2 returns 0x3C.
- Wrap: WIDTH=3, LOG2_DEPTH=3 -> lut[7] reads 0 after init.
- Reset mid-op: assert reset_n=0 with 2 lookups in flight -> no rsp_valid, ready=0, INIT reruns. lut[3] (previously 0xA5) reads back 4.
